// File: rtl/weight_skew_feeder.sv
// Double-buffered weight tile feeder: buffers ROWS x K_DEPTH tiles column-major and
// streams them to a systolic array with lane r delayed by r steps (zero-filled skew).
module weight_skew_feeder #(
  parameter int ROWS       = 4,
  parameter int K_DEPTH    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         hold,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROWS*DATA_WIDTH-1:0]   out_data,
  output logic                         out_first,
  output logic                         out_last,
  output logic [1:0]                   tiles_full
);

  localparam int S  = K_DEPTH + ROWS - 1;
  localparam int RW = $clog2(ROWS) + 1;
  localparam int CW = $clog2(K_DEPTH) + 1;
  localparam int SW = $clog2(S) + 1;

  // Handshake: a word moves on in_valid && in_ready, a step moves on out_valid && out_ready;
  // out_* never change while out_valid && !out_ready.
  logic signed [DATA_WIDTH-1:0] mem [2][ROWS][K_DEPTH];

  logic            alive;
  logic            wr_bank;
  logic            rd_bank;
  logic [RW-1:0]   wr_row;
  logic [CW-1:0]   wr_col;
  logic [SW-1:0]   step;
  logic [1:0]      full;
  logic [ROWS*DATA_WIDTH-1:0] step_data;

  logic in_fire;
  logic wr_last;
  logic load;
  logic step_last;

  assign in_ready   = alive && !full[wr_bank] && !flush;
  assign in_fire    = in_valid && in_ready;
  assign wr_last    = (wr_row == RW'(ROWS - 1)) && (wr_col == CW'(K_DEPTH - 1));
  assign load       = (!out_valid || out_ready) && full[rd_bank] && !flush;
  assign step_last  = (step == SW'(S - 1));
  assign tiles_full = full;

  // Lane r at step s carries column s-r; every other lane/step combination is zero.
  always_comb begin
    step_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < K_DEPTH; c++) begin
        if (step == SW'(r + c)) begin
          step_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_bank][r][c];
        end
      end
    end
  end

  // Storage is deliberately not reset; outputs only ever read completed tiles.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < K_DEPTH; c++) begin
          if (wr_row == RW'(r) && wr_col == CW'(c)) begin
            mem[wr_bank][r][c] <= in_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alive     <= 1'b0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      step      <= '0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      alive     <= 1'b1;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      step      <= '0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (in_fire) begin
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_row        <= '0;
          wr_col        <= '0;
        end else if (wr_row == RW'(ROWS - 1)) begin
          wr_row <= '0;
          wr_col <= wr_col + 1'b1;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= step_data;
        out_first <= (step == '0);
        out_last  <= step_last;
        if (step_last) begin
          step <= '0;
          // The filling bank is never the full read bank, so both flag updates can land together.
          if (!hold) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
          end
        end else begin
          step <= step + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weight_skew_feeder.sv
// Bench for weight_skew_feeder (ROWS=2, K_DEPTH=3): directed tiles, expected skewed steps
// queued at issue time and popped by an independent output monitor.
module tb_weight_skew_feeder;

  localparam int ROWS = 2;
  localparam int KD   = 3;
  localparam int DW   = 16;
  localparam int EW   = ROWS*DW + 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 hold = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ROWS*DW-1:0]   out_data;
  logic                 out_first;
  logic                 out_last;
  logic [1:0]           tiles_full;

  weight_skew_feeder #(.ROWS(ROWS), .K_DEPTH(KD), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hold(hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .tiles_full(tiles_full)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int rdy_mode = 0;   // 0: stall, 1: always ready, 2: random
  bit hold_en = 1'b0;
  int hold_base = 0;
  int last_cnt = 0;
  int first_cyc_q[$];
  int last_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit f, input bit l,
                                       input logic [DW-1:0] lane0, input logic [DW-1:0] lane1);
    return {f, l, lane1, lane0};
  endfunction

  // Hand-derived skew for a 2x3 tile of words base..base+5 (column-major).
  task automatic push_tile(input logic [DW-1:0] base);
    exp_q.push_back(mk(1'b1, 1'b0, base,        16'd0));
    exp_q.push_back(mk(1'b0, 1'b0, base + 16'd2, base + 16'd1));
    exp_q.push_back(mk(1'b0, 1'b0, base + 16'd4, base + 16'd3));
    exp_q.push_back(mk(1'b0, 1'b1, 16'd0,       base + 16'd5));
  endtask

  // ---------------- out_ready and hold drivers ----------------
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    hold = hold_en && ((last_cnt - hold_base) < 2);
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] snap;
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    bit prev_stall;
    prev_stall = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      cur = {out_first, out_last, out_data};
      if (rstn && out_valid) begin
        if (prev_stall) chk("stall_stable", cur, snap);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_step: got %0h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            chk("step", cur, e);
          end
          if (out_first) first_cyc_q.push_back(cyc);
          if (out_last) begin
            last_cyc_q.push_back(cyc);
            last_cnt++;
          end
        end
        prev_stall = !out_ready;
        snap = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic send_word(input logic [DW-1:0] w, output int tries, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    tries = 0;
    acc_cyc = -1;
    in_valid = 1'b1;
    in_data = w;
    while (!ok && tries < 400) begin
      @(negedge clk);
      tries++;
      if (in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL send_timeout: word %0h got no in_ready expected accept", w);
    end
  endtask

  task automatic send_tile(input logic [DW-1:0] base, output bit all_imm);
    int t;
    int c;
    all_imm = 1'b1;
    for (int i = 0; i < ROWS*KD; i++) begin
      send_word(base + DW'(i), t, c);
      if (t != 1) all_imm = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s_drain: got %0d pending steps expected 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit imm_a;
    bit imm_b;
    int t13;
    int c13;

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_first_last", {out_first, out_last}, 2'b00);
    chk("rst_tiles_full", tiles_full, 2'b00);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single tile, always ready
    rdy_mode = 1;
    push_tile(16'd1);
    send_tile(16'd1, imm_a);
    wait_drain("single");
    @(negedge clk);
    chk("single_tiles_full", tiles_full, 2'b00);
    @(posedge clk);
    #1;

    // Two tiles back-to-back
    push_tile(16'd1);
    push_tile(16'd7);
    send_tile(16'd1, imm_a);
    send_tile(16'd7, imm_b);
    chk("b2b_in_ready_steady", {imm_a, imm_b}, 2'b11);
    wait_drain("b2b");

    // Three tiles against a stalled consumer
    rdy_mode = 0;
    first_cyc_q.delete();
    last_cyc_q.delete();
    push_tile(16'd13);
    push_tile(16'd19);
    push_tile(16'd25);
    send_tile(16'd13, imm_a);
    send_tile(16'd19, imm_b);
    @(negedge clk);
    chk("both_full", tiles_full, 2'b11);
    chk("both_full_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    fork
      send_word(16'd25, t13, c13);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("w13_blocked", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rdy_mode = 1;
      end
    join
    for (int i = 1; i < ROWS*KD; i++) send_word(16'd25 + DW'(i), t13, imm_a);
    wait_drain("three");
    chk("w13_after_tile1_last",
        (last_cyc_q.size() >= 1) && (c13 >= last_cyc_q[0]), 1'b1);
    chk("no_bubble_tile2",
        (first_cyc_q.size() >= 2) && (last_cyc_q.size() >= 1) &&
        (first_cyc_q[1] == last_cyc_q[0] + 1), 1'b1);

    // Hold: the tile streams three times, then its bank frees
    hold_base = last_cnt;
    hold_en = 1'b1;
    for (int p = 0; p < 3; p++) push_tile(16'd31);
    send_tile(16'd31, imm_a);
    wait_drain("hold");
    hold_en = 1'b0;
    @(negedge clk);
    chk("hold_freed", tiles_full, 2'b00);
    @(posedge clk);
    #1;

    // Random consumer stalls
    rdy_mode = 2;
    push_tile(16'd41);
    push_tile(16'd47);
    send_tile(16'd41, imm_a);
    send_tile(16'd47, imm_b);
    rdy_mode = 1;
    wait_drain("stall");

    // Flush after a partial load, with a word presented in the flush cycle
    send_word(16'd50, t13, c13);
    send_word(16'd51, t13, c13);
    send_word(16'd52, t13, c13);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h0099;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_load_state", {out_valid, tiles_full, in_ready}, 4'b0001);
    @(posedge clk);
    #1;
    push_tile(16'd61);
    send_tile(16'd61, imm_a);
    wait_drain("flush_load");

    // Flush while a tile is presented on the output
    rdy_mode = 0;
    send_tile(16'd71, imm_a);
    wait_valid();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_stream_state", {out_valid, tiles_full}, 3'b000);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    push_tile(16'd81);
    send_tile(16'd81, imm_a);
    wait_drain("flush_stream");

    // Reset in the middle of a load
    send_word(16'd91, t13, c13);
    send_word(16'd92, t13, c13);
    send_word(16'd93, t13, c13);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {out_valid, tiles_full, in_ready, out_first, out_last}, 6'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    push_tile(16'd101);
    send_tile(16'd101, imm_a);
    wait_drain("mid_rst");
    @(negedge clk);
    chk("final_tiles_full", tiles_full, 2'b00);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/weight_skew_feeder.md
WEIGHT_SKEW_FEEDER -- requirements
Module: weight_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4: number of output lanes (PE rows); legal 2..64.
REQ-002 Parameter K_DEPTH, default 4: weight words per lane per tile; legal 1..64.
REQ-003 Parameter DATA_WIDTH, default 16: signed weight word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all buffered tiles and output.
REQ-007 in_valid  input  1  in_data holds a valid weight word.
REQ-008 in_ready  output  1  feeder accepts a word this cycle.
REQ-009 in_data  input  DATA_WIDTH  signed weight word.
REQ-010 hold  input  1  sampled at the last stream step; 1 = keep the tile for re-streaming.
REQ-011 out_valid  output  1  out_data holds a valid skewed step.
REQ-012 out_ready  input  1  consumer accepts the current step.
REQ-013 out_data  output  ROWS*DATA_WIDTH  lane r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-014 out_first  output  1  marks step 0 of a tile.
REQ-015 out_last  output  1  marks step K_DEPTH+ROWS-2 of a tile.
REQ-016 tiles_full  output  2  per-bank full flags (bit b = bank b).

Function
REQ-017 Two banks, each ROWS x K_DEPTH words; the write bank and the read bank pointers each start at bank 0.
REQ-018 A word transfers when in_valid && in_ready; in_ready = flags not full for the write bank and flush low.
REQ-019 Word order is column-major: for k = 0..K_DEPTH-1, for r = 0..ROWS-1; word n goes to row n mod ROWS, column n div ROWS.
REQ-020 On the ROWS*K_DEPTH-th accepted word, the write bank's full flag sets next edge; the write pointer toggles; the row and column counters return to 0.
REQ-021 Stream length S = K_DEPTH+ROWS-1 steps; at step s, lane r carries word (r, s-r) if 0 <= s-r < K_DEPTH, else 0.
REQ-022 The output register loads a step when (!out_valid || out_ready) and the read bank is full; out_valid rises one cycle after the read bank's flag is set (1-cycle latency).
REQ-023 out_data, out_first and out_last are stable while out_valid && !out_ready.
REQ-024 Steps of consecutive tiles are emitted back-to-back, with no bubble, when the other bank is already full.
REQ-025 When the step-S-1 load occurs with hold=0: the read bank's full flag clears, the read pointer toggles, and the step counter returns to 0.
REQ-026 When the step-S-1 load occurs with hold=1: the flag stays set, the pointer stays, and the step counter returns to 0 (the same tile re-streams).
REQ-027 A bank freed and a different bank filled in the same cycle both take effect.
REQ-028 A bank never accepts writes while its full flag is set; with both banks full, in_ready=0.
REQ-029 When the step counter is 0 and the read bank is empty, the output register loads nothing; out_valid falls once the last step is accepted.
REQ-030 Flush has priority over all activity and takes effect on the next edge; its resulting state equals the reset state, and words presented during that cycle are dropped.
REQ-031 Counters are sized $clog2 of their range plus 1; no data arithmetic is performed; zero-fill uses signed 0.

Reset
REQ-032 While rstn=0: out_valid=0, out_data=0, out_first=0, out_last=0, tiles_full=2'b00, in_ready=0.
REQ-033 After rstn deasserts, in_ready=1 from the first edge; all pointers and counters are 0.
REQ-034 Bank storage contents need not be reset; no output depends on unwritten storage.
REQ-035 Reset asserted mid-load or mid-stream aborts both operations immediately; no partial tile is emitted after release.

Verification (ROWS=2, K_DEPTH=3, DATA_WIDTH=16)
REQ-036 Load words 1..6 with out_ready=1 and hold=0 -> lane{0,1} steps {1,0},{3,2},{5,4},{0,6}; out_first on step 0; out_last on step 3; then tiles_full=00.
REQ-037 Load tile A (1..6) then tile B (7..12) back-to-back -> in_ready=1 throughout; B steps {7,0},{9,8},{11,10},{0,12} follow A with no gap.
REQ-038 Load three tiles with out_ready=0 -> after 12 words tiles_full=11 and in_ready=0; the 13th word is not accepted until the first tile's last step is accepted.
REQ-039 hold=1 at out_last for tile 1..6 -> the same four steps repeat; after hold=0 at a later out_last, the bank is freed.
REQ-040 Random out_ready stalls -> out_data is unchanged while stalled; the step sequence is identical to the no-stall case.
REQ-041 Assert flush (or rstn=0) after 3 words and mid-stream -> the next edge gives out_valid=0 and tiles_full=00; the next loaded tile 1..6 streams correctly.
